// File: rtl/clint.sv
// rtl/clint.sv - core-local interrupt/exception sequencer driving the CSR second write port
module clint #(
    parameter logic [31:0] CAUSE_ECALL  = 32'd11,
    parameter logic [31:0] CAUSE_EBREAK = 32'd3,
    parameter logic [31:0] CAUSE_EXT    = 32'h8000000B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  int_flag_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    input  logic [31:0] csr_mstatus,
    input  logic        global_int_en_i,
    output logic        hold_flag_o,
    output logic        we_o,
    output logic [31:0] waddr_o,
    output logic [31:0] raddr_o,
    output logic [31:0] data_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);

    localparam logic [31:0] INST_ECALL  = 32'h00000073;
    localparam logic [31:0] INST_EBREAK = 32'h00100073;
    localparam logic [31:0] INST_MRET   = 32'h30200073;
    localparam logic [31:0] ADDR_MSTATUS = 32'h00000300;
    localparam logic [31:0] ADDR_MEPC    = 32'h00000341;
    localparam logic [31:0] ADDR_MCAUSE  = 32'h00000342;

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MSTATUS,
        W_MCAUSE,
        MRET_STATUS,
        REDIRECT
    } state_t;

    state_t      state;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        ret_q;

    logic is_ecall;
    logic is_ebreak;
    logic is_sync;
    logic is_mret;
    logic is_async;
    logic event_hit;

    assign is_ecall  = (inst_i == INST_ECALL);
    assign is_ebreak = (inst_i == INST_EBREAK);
    assign is_sync   = is_ecall | is_ebreak;
    assign is_mret   = (inst_i == INST_MRET);
    assign is_async  = (int_flag_i != 8'd0) & global_int_en_i;
    assign event_hit = (state == IDLE) & (is_sync | is_mret | is_async);

    assign hold_flag_o = (state != IDLE) | event_hit;
    assign raddr_o     = 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cause <= 32'd0;
            epc   <= 32'd0;
            ret_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_sync) begin
                        state <= W_MEPC;
                        cause <= is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
                        epc   <= inst_addr_i;
                        ret_q <= 1'b0;
                    end else if (is_mret) begin
                        state <= MRET_STATUS;
                        ret_q <= 1'b1;
                    end else if (is_async) begin
                        state <= W_MEPC;
                        cause <= CAUSE_EXT;
                        // A taken branch in execute means the interrupted flow resumes at its target.
                        epc   <= jump_flag_i ? jump_addr_i : inst_addr_i;
                        ret_q <= 1'b0;
                    end
                end
                W_MEPC:      state <= W_MSTATUS;
                W_MSTATUS:   state <= W_MCAUSE;
                W_MCAUSE:    state <= REDIRECT;
                MRET_STATUS: state <= REDIRECT;
                REDIRECT:    state <= IDLE;
                default:     state <= IDLE;
            endcase
        end
    end

    always_comb begin
        we_o         = 1'b0;
        waddr_o      = 32'd0;
        data_o       = 32'd0;
        int_assert_o = 1'b0;
        int_addr_o   = 32'd0;
        case (state)
            W_MEPC: begin
                we_o    = 1'b1;
                waddr_o = ADDR_MEPC;
                data_o  = epc;
            end
            W_MSTATUS: begin
                we_o    = 1'b1;
                waddr_o = ADDR_MSTATUS;
                data_o  = {csr_mstatus[31:8], csr_mstatus[3], csr_mstatus[6:4], 1'b0, csr_mstatus[2:0]};
            end
            W_MCAUSE: begin
                we_o    = 1'b1;
                waddr_o = ADDR_MCAUSE;
                data_o  = cause;
            end
            MRET_STATUS: begin
                we_o    = 1'b1;
                waddr_o = ADDR_MSTATUS;
                data_o  = {csr_mstatus[31:8], 1'b1, csr_mstatus[6:4], csr_mstatus[7], csr_mstatus[2:0]};
            end
            REDIRECT: begin
                int_assert_o = 1'b1;
                int_addr_o   = ret_q ? csr_mepc : csr_mtvec;
            end
            default: ;
        endcase
    end

endmodule
